// File: rtl/core_dbg_pkg.sv
// Shared types and constants for the multi-hart debug controller.
// Halt causes, run-control states, abstract CSR addresses and the dcsr view layout.
package core_dbg_pkg;

  typedef enum logic [2:0] {
    CauseNone    = 3'd0,
    CauseEbreak  = 3'd1,
    CauseHaltreq = 3'd3,
    CauseStep    = 3'd4
  } dcause_e;

  typedef enum logic [1:0] {
    StRunning,
    StFlush,
    StHalted,
    StResume
  } dbg_state_e;

  localparam logic [15:0] CSR_DCSR = 16'h07B0;
  localparam logic [15:0] CSR_DPC  = 16'h07B1;

  localparam int unsigned DcsrEbreakm = 15;
  localparam int unsigned DcsrHiMsb   = 13;
  localparam int unsigned DcsrHiLsb   = 9;
  localparam int unsigned DcsrBit4    = 4;
  localparam int unsigned DcsrStep    = 2;

  // Fixed fields: xdebugver = 4 in the top nibble, prv = 3 (machine mode).
  function automatic logic [31:0] dcsr_pack(input logic ebreakm, input logic [4:0] hi,
                                            input dcause_e cause, input logic timeout,
                                            input logic b4, input logic step);
    return {4'd4, 12'd0, ebreakm, 1'b0, hi, cause, timeout, b4, 1'b0, step, 2'd3};
  endfunction

endpackage

// File: rtl/core_dbg_hart.sv
// Per-hart run-control FSM with its dcsr fields, dpc and bounded flush counter.
// Requests arrive already qualified by the hart's membership in the target set.
module core_dbg_hart
  import core_dbg_pkg::*;
#(
  parameter int unsigned     XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_DPC     = XLEN'(32'hFFFFF000),
  parameter int unsigned     FLUSH_TIMEOUT = 64,
  parameter bit              LINEAR        = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt_req,
  input  logic            resume_req,
  input  logic            resume_hold,
  input  logic            ebreak,
  input  logic [XLEN-1:0] ebreak_pc,
  input  logic            inst_valid_wb,
  input  logic [XLEN-1:0] wb_pc_next,
  input  logic            branch_wb,
  input  logic [XLEN-1:0] pc_jump_wb,
  input  logic            empty_core,
  input  logic            dcsr_we,
  input  logic            dpc_we,
  input  logic [XLEN-1:0] wdata,
  output logic            running,
  output logic            halted,
  output logic            resumeack,
  output logic            flush,
  output logic            dbg_ret,
  output logic            debug_on,
  output logic [XLEN-1:0] dcsr,
  output logic [XLEN-1:0] dpc
);

  localparam int unsigned CntW = $clog2(FLUSH_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(FLUSH_TIMEOUT - 1);

  dbg_state_e      state;
  dcause_e         cause;
  logic            timeout;
  logic            ebreakm;
  logic [4:0]      dcsr_hi;
  logic            dcsr_b4;
  logic            step;
  logic [CntW-1:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StRunning;
      cause     <= CauseNone;
      timeout   <= 1'b0;
      ebreakm   <= 1'b0;
      dcsr_hi   <= '0;
      dcsr_b4   <= 1'b0;
      step      <= 1'b0;
      dpc       <= RESET_DPC;
      flush_cnt <= '0;
      dbg_ret   <= 1'b0;
    end else begin
      dbg_ret <= 1'b0;
      unique case (state)
        StRunning: begin
          if (halt_req) begin
            state     <= StFlush;
            flush_cnt <= '0;
          end else if (ebreak && ebreakm) begin
            state   <= StHalted;
            cause   <= CauseEbreak;
            timeout <= 1'b0;
          end else if (step && inst_valid_wb) begin
            state   <= StHalted;
            cause   <= CauseStep;
            timeout <= 1'b0;
          end
        end
        StFlush: begin
          if (empty_core) begin
            state   <= StHalted;
            cause   <= CauseHaltreq;
            timeout <= 1'b0;
          end else if (flush_cnt == CntLast) begin
            state   <= StHalted;
            cause   <= CauseHaltreq;
            timeout <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        StHalted: begin
          if (resume_req) state <= StResume;
        end
        StResume: begin
          if (!resume_hold) begin
            state   <= StRunning;
            dbg_ret <= 1'b1;
          end
        end
        default: state <= StRunning;
      endcase

      // dpc tracks the next PC to execute only while the hart is still executing.
      if (state == StRunning || state == StFlush) begin
        if (ebreak) begin
          dpc <= ebreak_pc;
        end else if (inst_valid_wb && (step || state == StFlush)) begin
          dpc <= branch_wb ? pc_jump_wb : wb_pc_next;
        end
      end

      if (dcsr_we) begin
        ebreakm <= wdata[DcsrEbreakm];
        dcsr_hi <= wdata[DcsrHiMsb:DcsrHiLsb];
        dcsr_b4 <= wdata[DcsrBit4];
        step    <= wdata[DcsrStep];
      end
      if (dpc_we) dpc <= wdata;
    end
  end

  assign running   = (state == StRunning) || (state == StFlush);
  assign halted    = (state == StHalted) || (state == StResume);
  assign resumeack = (state == StResume);
  assign flush     = (state == StFlush);
  assign debug_on  = LINEAR ? 1'b1 : (ebreakm | step);
  assign dcsr      = XLEN'(dcsr_pack(ebreakm, dcsr_hi, cause, timeout, dcsr_b4, step));

endmodule

// File: rtl/core_dbg_ctrl_mh.sv
// Multi-hart debug control: target decode, per-hart controllers, halt/resume
// summary flags and the registered abstract CSR access path with error reporting.
module core_dbg_ctrl_mh
  import core_dbg_pkg::*;
#(
  parameter int unsigned     NHARTS        = 2,
  parameter int unsigned     XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_DPC     = XLEN'(32'hFFFFF000),
  parameter int unsigned     FLUSH_TIMEOUT = 64,
  parameter int unsigned     LINEAR        = 0,
  localparam int unsigned    HW            = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [HW-1:0]          hartsel_i,
  input  logic [NHARTS-1:0]      hamask_i,
  input  logic                   haltreq_i,
  input  logic                   resumereq_i,
  input  logic [NHARTS-1:0]      ebreak_mem_i,
  input  logic [NHARTS*XLEN-1:0] ebreak_pc_i,
  input  logic [NHARTS-1:0]      inst_valid_wb_i,
  input  logic [NHARTS*XLEN-1:0] wb_pc_next_i,
  input  logic [NHARTS-1:0]      branch_wb_i,
  input  logic [NHARTS*XLEN-1:0] pc_jump_wb_i,
  input  logic [NHARTS-1:0]      empty_core_i,
  input  logic                   ar_en_i,
  input  logic                   ar_wr_i,
  input  logic [15:0]            ar_ad_i,
  input  logic [XLEN-1:0]        ar_wdata_i,
  output logic [XLEN-1:0]        ar_rdata_o,
  output logic                   ar_rvalid_o,
  output logic                   ar_err_o,
  output logic [NHARTS-1:0]      running_o,
  output logic [NHARTS-1:0]      halted_o,
  output logic [NHARTS-1:0]      resumeack_o,
  output logic [NHARTS-1:0]      flush_o,
  output logic [NHARTS-1:0]      dbg_ret_o,
  output logic [NHARTS-1:0]      debug_on_o,
  output logic                   anyhalted_o,
  output logic                   allhalted_o,
  output logic                   anyresumeack_o,
  output logic                   allresumeack_o,
  output logic [NHARTS*XLEN-1:0] dcsr_o,
  output logic [NHARTS*XLEN-1:0] dpc_o
);

  logic [NHARTS-1:0] tgt;
  logic [XLEN-1:0]   dcsr_w [NHARTS];
  logic [XLEN-1:0]   dpc_w  [NHARTS];

  logic            is_dcsr, is_dpc, sel_valid, ar_err_d, wr_ok;
  logic [HW-1:0]   sel_idx;
  logic [XLEN-1:0] rdata_d;

  always_comb begin
    is_dcsr   = (ar_ad_i == CSR_DCSR);
    is_dpc    = (ar_ad_i == CSR_DPC);
    sel_valid = ({1'b0, hartsel_i} < (HW + 1)'(NHARTS));
    sel_idx   = sel_valid ? hartsel_i : '0;
    ar_err_d  = !(is_dcsr || is_dpc) || !sel_valid || (ar_wr_i && !halted_o[sel_idx]);
    wr_ok     = ar_en_i && ar_wr_i && !ar_err_d;
    rdata_d   = '0;
    if (!ar_err_d && !ar_wr_i) rdata_d = is_dcsr ? dcsr_w[sel_idx] : dpc_w[sel_idx];
  end

  for (genvar h = 0; h < NHARTS; h++) begin : g_hart
    // An out-of-range hartsel never matches, so it contributes nothing to the target set.
    assign tgt[h] = (hartsel_i == HW'(h)) | hamask_i[h];

    core_dbg_hart #(
      .XLEN         (XLEN),
      .RESET_DPC    (RESET_DPC),
      .FLUSH_TIMEOUT(FLUSH_TIMEOUT),
      .LINEAR       (LINEAR != 0)
    ) u_hart (
      .clk          (clk_i),
      .rst_n        (reset_ni),
      .halt_req     (haltreq_i && tgt[h]),
      .resume_req   (resumereq_i && tgt[h]),
      .resume_hold  (resumereq_i),
      .ebreak       (ebreak_mem_i[h]),
      .ebreak_pc    (ebreak_pc_i[h*XLEN +: XLEN]),
      .inst_valid_wb(inst_valid_wb_i[h]),
      .wb_pc_next   (wb_pc_next_i[h*XLEN +: XLEN]),
      .branch_wb    (branch_wb_i[h]),
      .pc_jump_wb   (pc_jump_wb_i[h*XLEN +: XLEN]),
      .empty_core   (empty_core_i[h]),
      .dcsr_we      (wr_ok && is_dcsr && (hartsel_i == HW'(h))),
      .dpc_we       (wr_ok && is_dpc && (hartsel_i == HW'(h))),
      .wdata        (ar_wdata_i),
      .running      (running_o[h]),
      .halted       (halted_o[h]),
      .resumeack    (resumeack_o[h]),
      .flush        (flush_o[h]),
      .dbg_ret      (dbg_ret_o[h]),
      .debug_on     (debug_on_o[h]),
      .dcsr         (dcsr_w[h]),
      .dpc          (dpc_w[h])
    );

    assign dcsr_o[h*XLEN +: XLEN] = dcsr_w[h];
    assign dpc_o[h*XLEN +: XLEN]  = dpc_w[h];
  end

  // "all" flags require a non-empty target set.
  assign anyhalted_o    = |(halted_o & tgt);
  assign allhalted_o    = (|tgt) && (&(halted_o | ~tgt));
  assign anyresumeack_o = |(resumeack_o & tgt);
  assign allresumeack_o = (|tgt) && (&(resumeack_o | ~tgt));

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      ar_rvalid_o <= 1'b0;
      ar_err_o    <= 1'b0;
      ar_rdata_o  <= '0;
    end else begin
      ar_rvalid_o <= ar_en_i;
      ar_err_o    <= ar_en_i && ar_err_d;
      ar_rdata_o  <= ar_en_i ? rdata_d : '0;
    end
  end

endmodule

// File: tb/tb_core_dbg_ctrl_mh.sv
// Self-checking bench for core_dbg_ctrl_mh: a 2-hart instance for run control and
// abstract access, plus a 3-hart instance for out-of-range hart selection.
module tb_core_dbg_ctrl_mh;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // 2-hart DUT
  logic        rst_n, hartsel, haltreq, resumereq, ar_en, ar_wr;
  logic [1:0]  hamask, ebreak, ivwb, brwb, empty;
  logic [63:0] ebreak_pc, wbnext, pcjump;
  logic [15:0] ar_ad;
  logic [31:0] ar_wdata, ar_rdata;
  logic        ar_rvalid, ar_err, anyh, allh, anyra, allra;
  logic [1:0]  running, halted, resumeack, flush, dbg_ret, debug_on;
  logic [63:0] dcsr, dpc;

  core_dbg_ctrl_mh #(.NHARTS(2), .XLEN(32), .RESET_DPC(32'hFFFFF000), .FLUSH_TIMEOUT(8),
                     .LINEAR(0)) dut (
    .clk_i(clk), .reset_ni(rst_n), .hartsel_i(hartsel), .hamask_i(hamask),
    .haltreq_i(haltreq), .resumereq_i(resumereq), .ebreak_mem_i(ebreak),
    .ebreak_pc_i(ebreak_pc), .inst_valid_wb_i(ivwb), .wb_pc_next_i(wbnext),
    .branch_wb_i(brwb), .pc_jump_wb_i(pcjump), .empty_core_i(empty), .ar_en_i(ar_en),
    .ar_wr_i(ar_wr), .ar_ad_i(ar_ad), .ar_wdata_i(ar_wdata), .ar_rdata_o(ar_rdata),
    .ar_rvalid_o(ar_rvalid), .ar_err_o(ar_err), .running_o(running), .halted_o(halted),
    .resumeack_o(resumeack), .flush_o(flush), .dbg_ret_o(dbg_ret), .debug_on_o(debug_on),
    .anyhalted_o(anyh), .allhalted_o(allh), .anyresumeack_o(anyra),
    .allresumeack_o(allra), .dcsr_o(dcsr), .dpc_o(dpc)
  );

  // 3-hart DUT: hartsel = 3 is representable but out of range
  logic [1:0]  hartsel2;
  logic [2:0]  hamask2, empty2, zero3;
  logic        haltreq2, ar_en2, zero1;
  logic [15:0] ar_ad2;
  logic [95:0] zero96;
  logic [31:0] zero32, ar_rdata2;
  logic        ar_rvalid2, ar_err2, anyh2, allh2, anyra2, allra2;
  logic [2:0]  running2, halted2, resumeack2, flush2, dbg_ret2, debug_on2;
  logic [95:0] dcsr2, dpc2;

  core_dbg_ctrl_mh #(.NHARTS(3), .XLEN(32), .RESET_DPC(32'hFFFFF000), .FLUSH_TIMEOUT(8),
                     .LINEAR(0)) dut2 (
    .clk_i(clk), .reset_ni(rst_n), .hartsel_i(hartsel2), .hamask_i(hamask2),
    .haltreq_i(haltreq2), .resumereq_i(zero1), .ebreak_mem_i(zero3),
    .ebreak_pc_i(zero96), .inst_valid_wb_i(zero3), .wb_pc_next_i(zero96),
    .branch_wb_i(zero3), .pc_jump_wb_i(zero96), .empty_core_i(empty2), .ar_en_i(ar_en2),
    .ar_wr_i(zero1), .ar_ad_i(ar_ad2), .ar_wdata_i(zero32), .ar_rdata_o(ar_rdata2),
    .ar_rvalid_o(ar_rvalid2), .ar_err_o(ar_err2), .running_o(running2),
    .halted_o(halted2), .resumeack_o(resumeack2), .flush_o(flush2), .dbg_ret_o(dbg_ret2),
    .debug_on_o(debug_on2), .anyhalted_o(anyh2), .allhalted_o(allh2),
    .anyresumeack_o(anyra2), .allresumeack_o(allra2), .dcsr_o(dcsr2), .dpc_o(dpc2)
  );

  // Scoreboard entries: {check_rdata, expected_err, expected_rdata}
  logic [33:0] exp_q[$];
  string       name_q[$];

  function automatic logic [31:0] dcsr_model(input logic ebm, input logic [2:0] cause,
                                             input logic tmo, input logic stp);
    return {4'd4, 12'd0, ebm, 1'b0, 5'd0, cause, tmo, 1'b0, 1'b0, stp, 2'd3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_access(input string nm, input logic wr, input logic [15:0] ad,
                           input logic [31:0] wd, input logic chk_rd, input logic exp_err,
                           input logic [31:0] exp_rd);
    logic [33:0] e;
    string       n;
    exp_q.push_back({chk_rd, exp_err, exp_rd});
    name_q.push_back(nm);
    ar_en = 1'b1; ar_wr = wr; ar_ad = ad; ar_wdata = wd;
    tick();
    ar_en = 1'b0; ar_wr = 1'b0;
    for (int i = 0; i < 4 && !ar_rvalid; i++) tick();
    e = exp_q.pop_front();
    n = name_q.pop_front();
    checks++;
    if (ar_rvalid !== 1'b1) begin
      $display("FAIL %s_rvalid: got %b want 1", n, ar_rvalid);
    end else begin
      passes++;
      checks++;
      if (ar_err !== e[32]) $display("FAIL %s_err: got %b want %b", n, ar_err, e[32]);
      else passes++;
      if (e[33]) begin
        checks++;
        if (ar_rdata !== e[31:0]) $display("FAIL %s_rdata: got %h want %h", n, ar_rdata, e[31:0]);
        else passes++;
      end
    end
  endtask

  task automatic resume_one();
    resumereq = 1'b1; tick();
    resumereq = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    checks++; if (running !== 2'b11) $display("FAIL rst_running: got %b want 11", running); else passes++;
    checks++; if ({halted, resumeack, flush, dbg_ret, debug_on} !== 10'd0)
      $display("FAIL rst_status: got %b want 0", {halted, resumeack, flush, dbg_ret, debug_on});
    else passes++;
    checks++; if (dpc !== {2{32'hFFFFF000}}) $display("FAIL rst_dpc: got %h want %h", dpc, {2{32'hFFFFF000}}); else passes++;
    checks++; if (dcsr !== {2{32'h40000003}}) $display("FAIL rst_dcsr: got %h want %h", dcsr, {2{32'h40000003}}); else passes++;
    checks++; if ({ar_rvalid, ar_err, ar_rdata} !== 34'd0)
      $display("FAIL rst_ar: got %h want 0", {ar_rvalid, ar_err, ar_rdata});
    else passes++;
    rst_n = 1'b1; tick();
    hartsel = 1'b0;
    ar_access("rd_dcsr_run", 1'b0, 16'h07B0, 32'd0, 1'b1, 1'b0, 32'h40000003);
    hartsel = 1'b1;
    ar_access("rd_dpc_run", 1'b0, 16'h07B1, 32'd0, 1'b1, 1'b0, 32'hFFFFF000);
  endtask

  task automatic test_group_halt();
    hartsel = 1'b0; hamask = 2'b10; haltreq = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (flush !== 2'b11) $display("FAIL grp_flush%0d: got %b want 11", i, flush); else passes++;
      if (i == 2) empty = 2'b11;
      tick();
    end
    checks++; if (halted !== 2'b11) $display("FAIL grp_halted: got %b want 11", halted); else passes++;
    checks++; if ({anyh, allh} !== 2'b11) $display("FAIL grp_summary: got %b want 11", {anyh, allh}); else passes++;
    haltreq = 1'b0; empty = 2'b00; hamask = 2'b00;
    checks++; if (dcsr[63:32] !== dcsr_model(0, 3'd3, 0, 0))
      $display("FAIL grp_cause: got %h want %h", dcsr[63:32], dcsr_model(0, 3'd3, 0, 0));
    else passes++;
    ar_access("grp_rd_dcsr0", 1'b0, 16'h07B0, 32'd0, 1'b1, 1'b0, dcsr_model(0, 3'd3, 0, 0));
  endtask

  task automatic test_ebreak();
    hartsel = 1'b1;
    ar_access("eb_wr_dcsr", 1'b1, 16'h07B0, 32'h00008000, 1'b0, 1'b0, 32'd0);
    checks++; if (debug_on !== 2'b10) $display("FAIL eb_debug_on: got %b want 10", debug_on); else passes++;
    resume_one();
    checks++; if (halted !== 2'b01) $display("FAIL eb_resumed: got %b want 01", halted); else passes++;
    ebreak = 2'b10; ebreak_pc[63:32] = 32'h80000010;
    tick();
    ebreak = 2'b00;
    checks++; if (halted[1] !== 1'b1) $display("FAIL eb_halted: got %b want 1", halted[1]); else passes++;
    checks++; if (dpc[63:32] !== 32'h80000010) $display("FAIL eb_dpc: got %h want 80000010", dpc[63:32]); else passes++;
    checks++; if (dcsr[63:32] !== dcsr_model(1, 3'd1, 0, 0))
      $display("FAIL eb_dcsr: got %h want %h", dcsr[63:32], dcsr_model(1, 3'd1, 0, 0));
    else passes++;
  endtask

  task automatic test_step();
    hartsel = 1'b1;
    ar_access("st_wr_dcsr", 1'b1, 16'h07B0, 32'h00008004, 1'b0, 1'b0, 32'd0);
    resume_one();
    checks++; if (running[1] !== 1'b1) $display("FAIL st_running: got %b want 1", running[1]); else passes++;
    ivwb = 2'b10; brwb = 2'b10; pcjump[63:32] = 32'h80000100; wbnext[63:32] = 32'h80000004;
    tick();
    ivwb = 2'b00; brwb = 2'b00;
    checks++; if (halted[1] !== 1'b1) $display("FAIL st_halted: got %b want 1", halted[1]); else passes++;
    checks++; if (dpc[63:32] !== 32'h80000100) $display("FAIL st_dpc: got %h want 80000100", dpc[63:32]); else passes++;
    ar_access("st_rd_dcsr", 1'b0, 16'h07B0, 32'd0, 1'b1, 1'b0, dcsr_model(1, 3'd4, 0, 1));
  endtask

  task automatic test_resume_ack();
    hartsel = 1'b1; resumereq = 1'b1;
    tick();
    checks++; if ({resumeack, anyra, allra} !== 4'b1011)
      $display("FAIL ra_cycle1: got %b want 1011", {resumeack, anyra, allra});
    else passes++;
    tick();
    checks++; if ({resumeack[1], dbg_ret[1]} !== 2'b10)
      $display("FAIL ra_cycle2: got %b want 10", {resumeack[1], dbg_ret[1]});
    else passes++;
    resumereq = 1'b0;
    tick();
    checks++; if ({running[1], resumeack[1], dbg_ret[1]} !== 3'b101)
      $display("FAIL ra_ret: got %b want 101", {running[1], resumeack[1], dbg_ret[1]});
    else passes++;
    tick();
    checks++; if (dbg_ret !== 2'b00) $display("FAIL ra_ret_once: got %b want 00", dbg_ret); else passes++;
  endtask

  task automatic test_abstract_errors();
    hartsel = 1'b1;
    ar_access("err_wr_running", 1'b1, 16'h07B1, 32'h12345678, 1'b0, 1'b1, 32'd0);
    checks++; if (dpc[63:32] !== 32'h80000100) $display("FAIL err_dpc_kept: got %h want 80000100", dpc[63:32]); else passes++;
    ar_access("err_unmapped", 1'b0, 16'h07B2, 32'd0, 1'b1, 1'b1, 32'd0);
    ar_access("rd_dpc_running", 1'b0, 16'h07B1, 32'd0, 1'b1, 1'b0, 32'h80000100);
  endtask

  task automatic test_timeout_and_reset();
    int n;
    hartsel = 1'b0;
    resume_one();
    haltreq = 1'b1; tick(); haltreq = 1'b0;
    checks++; if (flush !== 2'b01) $display("FAIL to_flush: got %b want 01", flush); else passes++;
    n = 0;
    while (n < 20 && !halted[0]) begin tick(); n++; end
    checks++; if (n !== 8) $display("FAIL to_cycles: got %0d want 8", n); else passes++;
    checks++; if (dcsr[31:0] !== dcsr_model(0, 3'd3, 1, 0))
      $display("FAIL to_dcsr: got %h want %h", dcsr[31:0], dcsr_model(0, 3'd3, 1, 0));
    else passes++;
    // Reset in the middle of a flush, after a WB capture moved dpc away from its reset value.
    resume_one();
    haltreq = 1'b1; tick(); haltreq = 1'b0;
    ivwb = 2'b01; wbnext[31:0] = 32'h80000200; tick(); ivwb = 2'b00;
    checks++; if ({flush[0], dpc[31:0]} !== {1'b1, 32'h80000200})
      $display("FAIL fl_capture: got %h want %h", {flush[0], dpc[31:0]}, {1'b1, 32'h80000200});
    else passes++;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if ({running, flush, dpc[31:0]} !== {4'b1100, 32'hFFFFF000})
      $display("FAIL fl_reset: got %h want %h", {running, flush, dpc[31:0]}, {4'b1100, 32'hFFFFF000});
    else passes++;
  endtask

  task automatic test_hartsel_range();
    hartsel2 = 2'd0; hamask2 = 3'b111; haltreq2 = 1'b1; empty2 = 3'b111;
    tick(); tick();
    haltreq2 = 1'b0; empty2 = 3'b000;
    checks++; if (halted2 !== 3'b111) $display("FAIL hs_halted: got %b want 111", halted2); else passes++;
    hartsel2 = 2'd3; hamask2 = 3'b000; #1;
    checks++; if ({anyh2, allh2} !== 2'b00) $display("FAIL hs_empty_summary: got %b want 00", {anyh2, allh2}); else passes++;
    hamask2 = 3'b100; #1;
    checks++; if ({anyh2, allh2} !== 2'b11) $display("FAIL hs_mask_summary: got %b want 11", {anyh2, allh2}); else passes++;
    ar_en2 = 1'b1; ar_ad2 = 16'h07B0; tick(); ar_en2 = 1'b0;
    checks++; if ({ar_rvalid2, ar_err2, ar_rdata2} !== {2'b11, 32'd0})
      $display("FAIL hs_err: got %h want %h", {ar_rvalid2, ar_err2, ar_rdata2}, {2'b11, 32'd0});
    else passes++;
  endtask

  initial begin
    rst_n = 1'b0; hartsel = 1'b0; hamask = '0; haltreq = 1'b0; resumereq = 1'b0;
    ebreak = '0; ebreak_pc = '0; ivwb = '0; wbnext = '0; brwb = '0; pcjump = '0; empty = '0;
    ar_en = 1'b0; ar_wr = 1'b0; ar_ad = '0; ar_wdata = '0;
    hartsel2 = '0; hamask2 = '0; haltreq2 = 1'b0; empty2 = '0; ar_en2 = 1'b0; ar_ad2 = '0;
    zero1 = 1'b0; zero3 = '0; zero32 = '0; zero96 = '0;
    test_reset();
    test_group_halt();
    test_ebreak();
    test_step();
    test_resume_ack();
    test_abstract_errors();
    test_timeout_and_reset();
    test_hartsel_range();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
